// File: rtl/pip_hazard_ctrl.sv
// Hazard controller for an in-order pipeline: drives the per-register hold/clear
// enables for branch flush, load-use bubbles, multi-cycle EX ops and memory freeze.
module pip_hazard_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int REG_AW     = 5,
  parameter int MC_W       = 6,
  parameter int PERF_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  branch_taken,
  input  logic                  branch_mispredicted,
  input  logic [REG_AW-1:0]     id_rs1,
  input  logic [REG_AW-1:0]     id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_AW-1:0]     ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  mc_start,
  input  logic [MC_W-1:0]       mc_cycles,
  input  logic                  mem_stall,
  input  logic                  perf_clr,
  output logic [NUM_STAGES-2:0] stall,
  output logic [NUM_STAGES-2:0] flush,
  output logic                  mc_busy,
  output logic [PERF_W-1:0]     stall_cycles
);

  localparam int NR = NUM_STAGES - 1;

  typedef enum logic {IDLE, MC_BUSY} state_t;

  state_t            state_reg, state_next;
  logic [MC_W-1:0]   mc_cnt_reg, mc_cnt_next;
  logic [PERF_W-1:0] perf_reg;
  logic [NR-1:0]     stall_raw;
  logic [NR-1:0]     branch_flush;
  logic [NR-1:0]     flush_raw;
  logic              load_use;
  logic              mc_long;

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

  // Ops of 0 or 1 cycles never occupy EX beyond their first cycle.
  assign mc_long = mc_start && (mc_cycles >= MC_W'(2));

  always_comb begin
    state_next   = state_reg;
    mc_cnt_next  = mc_cnt_reg;
    stall_raw    = '0;
    branch_flush = '0;
    if (mem_stall) begin
      stall_raw = '1;
    end else if (state_reg == MC_BUSY) begin
      stall_raw[1:0] = 2'b11;
      if (mc_cnt_reg == MC_W'(1)) begin
        state_next = IDLE;
      end else begin
        mc_cnt_next = mc_cnt_reg - MC_W'(1);
      end
    end else if (branch_mispredicted) begin
      branch_flush[1:0] = 2'b11;
    end else if (branch_taken) begin
      branch_flush[0] = 1'b1;
    end else if (mc_long) begin
      stall_raw[1:0] = 2'b11;
      mc_cnt_next    = mc_cycles - MC_W'(2);
      state_next     = (mc_cycles == MC_W'(2)) ? IDLE : MC_BUSY;
    end else if (load_use) begin
      stall_raw[0] = 1'b1;
    end
  end

  // A held register feeding a moving one must hand it a bubble.
  assign flush_raw[0] = branch_flush[0];
  generate
    for (genvar gi = 1; gi < NR; gi++) begin : g_bubble
      assign flush_raw[gi] = branch_flush[gi] | (stall_raw[gi-1] & ~stall_raw[gi]);
    end
  endgenerate

  assign stall        = reset ? '0 : stall_raw;
  assign flush        = reset ? '0 : flush_raw;
  assign mc_busy      = !reset && (state_reg == MC_BUSY);
  assign stall_cycles = perf_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      mc_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      mc_cnt_reg <= mc_cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || perf_clr) begin
      perf_reg <= '0;
    end else if (stall[0] && (perf_reg != '1)) begin
      perf_reg <= perf_reg + PERF_W'(1);
    end
  end

endmodule
